result_serializer: RTL

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer.sv | 119 +++++++++++
 1 files changed

// File: rtl/result_serializer.sv
// Parallel-in, serial-out result port: captures one cipher block and shifts it
// out MSB first, one bit per cycle while the host holds cs low.
module result_serializer #(
    parameter int unsigned datasize = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [datasize-1:0] data_in,
    input  logic                cs,
    output logic                miso,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int unsigned CNT_W = $clog2(datasize);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(datasize - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [datasize-1:0] shreg;
    logic [datasize-1:0] shreg_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                overrun_nxt;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            overrun <= overrun_nxt;
        end
    end

    // Next-state and datapath update; a load while busy only raises overrun
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        overrun_nxt = overrun;
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    shreg_nxt   = data_in;
                    overrun_nxt = 1'b0;
                    state_nxt   = LOADED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOADED: begin
                if (load) begin
                    overrun_nxt = 1'b1;
                end
                if (!cs) begin
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (load) begin
                    overrun_nxt = 1'b1;
                end
                if (!cs) begin
                    if (cnt == LAST_BIT) begin
                        state_nxt = DONE;
                    end else begin
                        shreg_nxt = {shreg[datasize-2:0], 1'b0};
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status decode straight from the state register
    always_comb begin
        miso  = 1'b0;
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            LOADED: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            SHIFT: begin
                busy = 1'b1;
                miso = shreg[datasize-1];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                miso = 1'b0;
            end
        endcase
    end

endmodule
